// File: rtl/pipeline_step_ctrl.sv
// Run/step/halt controller producing the shared enable for all pipeline latches; counts enabled cycles.
// Commands take effect on the accepting edge; o_cmd_ready is low in STEP and DRAIN (commands held off).
`timescale 1ns/1ps
module pipeline_step_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    output logic                 o_cmd_ready,
    input  logic                 i_halt_detected,
    output logic                 o_enable,
    output logic                 o_halted,
    output logic [2:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_cycle_count
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    localparam int            DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [DW-1:0]        r_drain_cnt;
    logic [DW-1:0]        w_drain_nxt;
    logic [CNT_WIDTH-1:0] r_cycle_count;
    logic                 w_clear;
    logic                 w_accept;
    logic                 w_enable;
    logic                 w_ready;

    assign w_accept = i_cmd_valid & w_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (i_cmd)
                        CMD_RUN:   w_state_nxt = S_RUN;
                        CMD_STEP:  w_state_nxt = S_STEP;
                        CMD_CLEAR: w_clear     = 1'b1;
                        default:   w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                // A decoded HALT outranks a simultaneous STOP; the STOP is still consumed.
                if (i_halt_detected) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = DRAIN_LOAD;
                end else if (w_accept && i_cmd == CMD_STOP) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STEP: begin
                if (i_halt_detected) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = DRAIN_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                w_drain_nxt = r_drain_cnt - DW'(1);
                if (r_drain_cnt <= DW'(1)) begin
                    w_state_nxt = S_HALTED;
                    w_drain_nxt = '0;
                end
            end
            S_HALTED: begin
                if (w_accept && i_cmd == CMD_CLEAR) begin
                    w_state_nxt = S_IDLE;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_enable = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN);
        w_ready  = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_HALTED);
    end

    // Clear only happens with enable low, so zeroing and incrementing never really collide.
    always_ff @(posedge i_clock) begin
        if (i_reset || w_clear) begin
            r_cycle_count <= '0;
        end else if (w_enable && (r_cycle_count != {CNT_WIDTH{1'b1}})) begin
            r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
        end
    end

    assign o_enable      = w_enable;
    assign o_cmd_ready   = w_ready;
    assign o_halted      = (r_state == S_HALTED);
    assign o_state       = r_state;
    assign o_cycle_count = r_cycle_count;
endmodule
